// File: rtl/fetch_sequencer.sv
// Purpose : front-end fetch controller; owns the PC, issues one read per cycle to a
//           synchronous instruction memory and presents words to decode.
// Latency : issue in cycle c -> instr_valid in c+2; branch in c -> target visible in c+3.
// Backpr. : stall holds the output word; a word already in flight lands in a one-entry skid.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start                          begin/restart fetching at RESET_PC (IDLE/HALTED only)
//   stall                          decode not ready; output word held
//   branch_valid, branch_target    redirect request (FETCH only)
//   imem_en, imem_addr, imem_rdata instruction memory read port (1-cycle read latency)
//   instr, instr_pc, instr_valid   word to decode, consumed at an edge with stall=0
//   done                           halt opcode reached; held until start or reset
module fetch_sequencer #(
    parameter int                ADDR_W      = 7,
    parameter int                DATA_W      = 32,
    parameter logic [4:0]        HALT_OPCODE = 5'b01011,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Program counter and the tag of the read currently in flight.
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_vld_q, if_vld_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;

    // Output register presented to decode.
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_dat_q, out_dat_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;

    // One-entry skid catching the word that returns while the output is held.
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic done_q, done_d;

    logic in_fetch;
    logic redirect;
    logic restart;
    logic out_free;
    logic skid_halt;
    logic resp_halt;
    logic halt_detect;

    assign in_fetch  = (state_q == S_FETCH);
    assign redirect  = in_fetch && branch_valid;
    assign restart   = start && (state_q != S_FETCH);
    // Output register may be loaded this edge: empty, or its word is being taken.
    assign out_free  = !out_vld_q || !stall;
    assign skid_halt = (skid_dat_q[DATA_W-1 -: 5] == HALT_OPCODE);
    assign resp_halt = (imem_rdata[DATA_W-1 -: 5] == HALT_OPCODE);

    // Halt fires only when the halt word would actually move into the output
    // register. The skid is older than any returning word, so it is looked at first.
    // A skid-full cycle never coincides with a returning word: the skid fills only
    // under stall, and stall also blocks issue.
    assign halt_detect = in_fetch && !branch_valid && out_free &&
                         (skid_vld_q ? skid_halt : (if_vld_q && resp_halt));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start)       state_d = S_FETCH;
            S_FETCH:  if (halt_detect) state_d = S_HALTED;
            S_HALTED: if (start)       state_d = S_FETCH;
            default:                   state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_en = in_fetch && !stall && !branch_valid && !halt_detect;
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        pc_d       = pc_q;
        if_vld_d   = if_vld_q;
        if_pc_d    = if_pc_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_pc_d   = out_pc_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        skid_pc_d  = skid_pc_q;
        done_d     = done_q;

        if (restart) begin
            pc_d       = RESET_PC;
            done_d     = 1'b0;
            if_vld_d   = 1'b0;
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (redirect) begin
            // Everything younger than the branch is wrong-path.
            pc_d       = branch_target;
            if_vld_d   = 1'b0;
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (halt_detect) begin
            // Any word in the output register is being consumed this edge.
            done_d     = 1'b0 | 1'b1;
            if_vld_d   = 1'b0;
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            if_vld_d = imem_en;
            if (imem_en) begin
                pc_d    = pc_q + 1'b1;
                if_pc_d = pc_q;
            end

            if (out_free) begin
                if (skid_vld_q) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = skid_dat_q;
                    out_pc_d   = skid_pc_q;
                    skid_vld_d = 1'b0;
                end else if (if_vld_q) begin
                    out_vld_d = 1'b1;
                    out_dat_d = imem_rdata;
                    out_pc_d  = if_pc_q;
                end else begin
                    out_vld_d = 1'b0;
                end
            end else if (if_vld_q) begin
                skid_vld_d = 1'b1;
                skid_dat_d = imem_rdata;
                skid_pc_d  = if_pc_q;
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            if_vld_q   <= 1'b0;
            if_pc_q    <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_pc_q   <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            skid_pc_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_vld_q   <= if_vld_d;
            if_pc_q    <= if_pc_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_pc_q   <= out_pc_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            skid_pc_q  <= skid_pc_d;
            done_q     <= done_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = out_dat_q;
    assign instr_pc    = out_pc_q;
    assign instr_valid = out_vld_q;
    assign done        = done_q;

endmodule
